// File: rtl/rtc_tick_pkg.sv
// Shared types and defaults for the RTC tick generator.
package rtc_tick_pkg;
  typedef enum logic {RTC_MODE_INT = 1'b0, RTC_MODE_EXT = 1'b1} rtc_mode_e;

  localparam int RTC_FILTER_LEN  = 3;
  localparam int RTC_DIV_WIDTH   = 16;
  localparam int RTC_DEFAULT_DIV = 100;
endpackage

// File: rtl/rtc_sync.sv
// N-stage synchroniser for asynchronous single-bit inputs, synchronous active-low reset.
module rtc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_pipe;

  always_ff @(posedge clock) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], d};
  end

  assign q = sync_pipe[SYNC_STAGES-1];
endmodule

// File: rtl/rtc_tick_gen.sv
// RTC tick source for the core-local interruptor: programmable divider or synchronised external edge.
// Optional glitch filter on the external input enabled by RTC_TICK_GEN_FILTER_EN.
module rtc_tick_gen
  import rtc_tick_pkg::*;
#(
  parameter int DIV_WIDTH   = RTC_DIV_WIDTH,
  parameter int DEFAULT_DIV = RTC_DEFAULT_DIV,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_enable,
  input  logic                 io_mode,
  input  logic                 io_div_load,
  input  logic [DIV_WIDTH-1:0] io_div_value,
  input  logic                 io_rtc_ext,
  output logic [DIV_WIDTH-1:0] io_div_ratio,
  output logic                 io_rtcTick
);
  logic [DIV_WIDTH-1:0] div_cnt, div_cnt_nxt, div_ratio_nxt, eff_m1;
  logic                 tick_nxt;
  rtc_mode_e            mode, mode_q;
  logic                 s, f, prev, rise;

  assign mode = rtc_mode_e'(io_mode);

  rtc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (io_rtc_ext),
    .q     (s)
  );

`ifdef RTC_TICK_GEN_FILTER_EN
  // f follows s only after s has disagreed with it for RTC_FILTER_LEN cycles in a row.
  logic [1:0] filt_cnt;
  logic       filt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      filt_cnt <= '0;
      filt_q   <= 1'b0;
    end else if (s != filt_q) begin
      if (filt_cnt == 2'(RTC_FILTER_LEN - 1)) begin
        filt_q   <= s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 2'd1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign f = filt_q;
`else
  assign f = s;
`endif

  assign rise   = f & ~prev;
  // A stored ratio of 0 behaves as 1.
  assign eff_m1 = (io_div_ratio == '0) ? '0 : io_div_ratio - DIV_WIDTH'(1);

  always_comb begin
    div_cnt_nxt   = div_cnt;
    div_ratio_nxt = io_div_ratio;
    tick_nxt      = 1'b0;
    if (io_div_load) begin
      div_ratio_nxt = io_div_value;
      div_cnt_nxt   = '0;
    end else if (mode != mode_q) begin
      div_cnt_nxt = '0;
    end else if (io_enable) begin
      if (mode == RTC_MODE_EXT) begin
        div_cnt_nxt = '0;
        tick_nxt    = rise;
      end else if (div_cnt == eff_m1) begin
        div_cnt_nxt = '0;
        tick_nxt    = 1'b1;
      end else begin
        div_cnt_nxt = div_cnt + DIV_WIDTH'(1);
      end
    end
  end

  // prev tracks f even when paused so a stale edge is never emitted later.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt      <= '0;
      io_div_ratio <= DIV_WIDTH'(DEFAULT_DIV);
      io_rtcTick   <= 1'b0;
      prev         <= 1'b0;
      mode_q       <= RTC_MODE_INT;
    end else begin
      div_cnt      <= div_cnt_nxt;
      io_div_ratio <= div_ratio_nxt;
      io_rtcTick   <= tick_nxt;
      prev         <= f;
      mode_q       <= mode;
    end
  end
endmodule

// File: tb/tb_rtc_tick_gen.sv
// Scoreboard bench: stimulus queues expected tick cycles, a negedge monitor pops and compares.
module tb_rtc_tick_gen;
  localparam int DW = 16;
`ifdef RTC_TICK_GEN_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic          clock, reset, io_enable, io_mode, io_div_load, io_rtc_ext, io_rtcTick;
  logic [DW-1:0] io_div_value, io_div_ratio;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];

  rtc_tick_gen dut (
    .clock        (clock),
    .reset        (reset),
    .io_enable    (io_enable),
    .io_mode      (io_mode),
    .io_div_load  (io_div_load),
    .io_div_value (io_div_value),
    .io_rtc_ext   (io_rtc_ext),
    .io_div_ratio (io_div_ratio),
    .io_rtcTick   (io_rtcTick)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tick must match the next queued expected cycle.
  always @(negedge clock) begin
    if (io_rtcTick === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tick: tick at cycle %0d, none expected", cyc);
      end else begin
        check("tick_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  // Returns #1 after edge n, so inputs driven next are sampled at edge n+1.
  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int R, L, M, X, E, H, Y, A, B, C, P, G;

  initial begin
    reset = 1'b0; io_enable = 1'b1; io_mode = 1'b0; io_div_load = 1'b0;
    io_div_value = '0; io_rtc_ext = 1'b0;

    // Reset state
    wait_until(3);
    check("reset_tick", int'(io_rtcTick), 0);
    check("reset_ratio", int'(io_div_ratio), 100);
    R = cyc;
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(R + 100 * k);

    // Load 4 on the terminal-count edge: no tick there, then every 4
    L = R + 600;
    wait_until(L - 1);
    io_div_load = 1'b1; io_div_value = 16'd4;
    wait_until(L);
    io_div_load = 1'b0;
    check("ratio_after_load4", int'(io_div_ratio), 4);
    for (int k = 1; k <= 3; k++) exp_q.push_back(L + 4 * k);

    // Ratio 0 behaves as 1
    M = L + 13;
    wait_until(M - 1);
    io_div_load = 1'b1; io_div_value = 16'd0;
    wait_until(M);
    io_div_load = 1'b0;
    for (int k = 1; k <= 5; k++) exp_q.push_back(M + k);
    wait_until(M + 1);
    check("ratio_zero", int'(io_div_ratio), 0);
    wait_until(M + 5);
    io_div_load = 1'b1; io_div_value = 16'd100;
    wait_until(M + 6);
    io_div_load = 1'b0;

    // External mode: square wave, 37-cycle half period
    X = M + 7;
    wait_until(X - 1);
    io_mode = 1'b1;
    E = X + 5;
    for (int k = 0; k < 3; k++) begin
      wait_until(E - 1);
      exp_q.push_back(E + LAT);
      io_rtc_ext = 1'b1;
      wait_until(E + 36);
      io_rtc_ext = 1'b0;
      E = E + 74;
    end
    wait_until(E);

`ifdef RTC_TICK_GEN_FILTER_EN
    // 2-cycle glitch must be filtered out
    G = E + 5;
    wait_until(G - 1);
    io_rtc_ext = 1'b1;
    wait_until(G + 1);
    io_rtc_ext = 1'b0;
    E = G + 20;
    wait_until(E);
`endif

    // Mode switches with s held high
    H = E + 2;
    wait_until(H - 1);
    io_rtc_ext = 1'b1;
    exp_q.push_back(H + LAT);
    Y = H + 21;
    wait_until(Y - 1);
    io_mode = 1'b0;
    exp_q.push_back(Y + 100);
    wait_until(Y + 129);
    io_mode = 1'b1;
    wait_until(Y + 140);
    io_rtc_ext = 1'b0;
    wait_until(Y + 150);

    // Pause at div_cnt = 50 for 20 cycles, external edge arrives meanwhile
    A = Y + 151;
    io_mode = 1'b0;
    exp_q.push_back(A + 100);
    exp_q.push_back(A + 220);
    wait_until(A + 150);
    io_enable = 1'b0;
    wait_until(A + 155);
    io_rtc_ext = 1'b1;
    wait_until(A + 170);
    io_enable = 1'b1;
    wait_until(A + 225);

    // External edge seen while paused is never emitted
    B = A + 226;
    io_mode = 1'b1;
    wait_until(B + 5);
    io_rtc_ext = 1'b0;
    wait_until(B + 15);
    io_enable = 1'b0;
    wait_until(B + 20);
    io_rtc_ext = 1'b1;
    wait_until(B + 35);
    io_enable = 1'b1;
    wait_until(B + 60);
    io_rtc_ext = 1'b0;

    // Reset mid-count (div_cnt = 73) with ratio 200
    C = B + 61;
    io_mode = 1'b0; io_div_load = 1'b1; io_div_value = 16'd200;
    wait_until(C);
    io_div_load = 1'b0;
    wait_until(C + 73);
    reset = 1'b0;
    wait_until(C + 76);
    check("midcount_reset_tick", int'(io_rtcTick), 0);
    check("midcount_reset_ratio", int'(io_div_ratio), 100);
    P = cyc;
    reset = 1'b1;
    exp_q.push_back(P + 100);
    wait_until(P + 101);

    // Reset with an external edge in flight
    io_mode = 1'b1;
    G = P + 110;
    wait_until(G - 1);
    io_rtc_ext = 1'b1;
    wait_until(G);
    reset = 1'b0; io_rtc_ext = 1'b0;
    wait_until(G + 1);
    check("ext_reset_tick", int'(io_rtcTick), 0);
    check("ext_reset_ratio", int'(io_div_ratio), 100);
    reset = 1'b1;
    wait_until(G + 30);

    check("pending_ticks", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
